// File: rtl/regfile_wb_ctrl_pkg.sv
// regfile_pkg: register file sizing constants and write-back requester identifiers.
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W = $clog2(NUM_REGS);
  typedef enum logic {REQ_ALU, REQ_LSU} req_id_e;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// regfile_wb_ctrl_if: write-back requests, scoreboard/hazard lookups and register file write port.
interface regfile_wb_ctrl_if
  import regfile_pkg::*;
#(
  parameter int N = DATA_W
);
  logic              alu_valid_i;
  logic [ADDR_W-1:0] alu_addr_i;
  logic [N-1:0]      alu_data_i;
  logic              alu_ready_o;
  logic              lsu_valid_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [N-1:0]      lsu_data_i;
  logic              lsu_ready_o;
  logic              reserve_valid_i;
  logic [ADDR_W-1:0] reserve_addr_i;
  logic [ADDR_W-1:0] rd_addr1_i;
  logic [ADDR_W-1:0] rd_addr2_i;
  logic              hazard1_o;
  logic              hazard2_o;
  logic [NUM_REGS-1:0] busy_o;
  logic              wr_enable_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [N-1:0]      wr_data_o;
  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i, lsu_valid_i, lsu_addr_i, lsu_data_i,
           reserve_valid_i, reserve_addr_i, rd_addr1_i, rd_addr2_i,
    output alu_ready_o, lsu_ready_o, hazard1_o, hazard2_o, busy_o, wr_enable_o, wr_addr_o, wr_data_o
  );
  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i, lsu_valid_i, lsu_addr_i, lsu_data_i,
           reserve_valid_i, reserve_addr_i, rd_addr1_i, rd_addr2_i,
    input  alu_ready_o, lsu_ready_o, hazard1_o, hazard2_o, busy_o, wr_enable_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/regfile_wb_ctrl_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; the pointer names the winner of the next contention.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst_i,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic alu_gnt,
  output logic lsu_gnt
);
  req_id_e ptr;
  always_comb begin
    alu_gnt = alu_valid && (!lsu_valid || ptr == REQ_ALU);
    lsu_gnt = lsu_valid && (!alu_valid || ptr == REQ_LSU);
  end
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) ptr <= REQ_ALU;
    else if (alu_gnt) ptr <= REQ_LSU;
    else if (lsu_gnt) ptr <= REQ_ALU;
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: arbitrates ALU/LSU onto the register file write port and tracks busy registers.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int N = DATA_W
) (
  input logic clk,
  input logic rst_i,
  regfile_wb_ctrl_if.slave bus
);
  logic alu_gnt, lsu_gnt;
  req_id_e gnt_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [N-1:0] sel_data;
  logic [NUM_REGS-1:0] busy, set_mask, clr_mask;
  logic wr_enable;
  logic [ADDR_W-1:0] wr_addr;
  logic [N-1:0] wr_data;
  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_i     (rst_i),
    .alu_valid (bus.alu_valid_i),
    .lsu_valid (bus.lsu_valid_i),
    .alu_gnt   (alu_gnt),
    .lsu_gnt   (lsu_gnt)
  );
  always_comb begin
    gnt_id   = lsu_gnt ? REQ_LSU : REQ_ALU;
    sel_addr = gnt_id == REQ_LSU ? bus.lsu_addr_i : bus.alu_addr_i;
    sel_data = gnt_id == REQ_LSU ? bus.lsu_data_i : bus.alu_data_i;
    set_mask = bus.reserve_valid_i ? NUM_REGS'(1) << bus.reserve_addr_i : '0;
    clr_mask = wr_enable ? NUM_REGS'(1) << wr_addr : '0;
  end
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_enable <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= '0;
    end else begin
      wr_enable <= alu_gnt || lsu_gnt;
      if (alu_gnt || lsu_gnt) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
      // a reservation landing on the same edge as the write beats the clear
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end
  assign bus.alu_ready_o = alu_gnt;
  assign bus.lsu_ready_o = lsu_gnt;
  assign bus.wr_enable_o = wr_enable;
  assign bus.wr_addr_o   = wr_addr;
  assign bus.wr_data_o   = wr_data;
  assign bus.busy_o      = busy;
  assign bus.hazard1_o   = busy[bus.rd_addr1_i];
  assign bus.hazard2_o   = busy[bus.rd_addr2_i];
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed scenarios for the write-back controller with hand-computed expectations.
module tb_regfile_wb_ctrl;
  import regfile_pkg::*;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  int checks = 0;
  int failures = 0;
  regfile_wb_ctrl_if #(.N(32)) bus ();
  regfile_wb_ctrl #(.N(32)) dut (.clk(clk), .rst_i(rst_i), .bus(bus));
  always #5 clk = ~clk;

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.wr_enable_o !== 1'b0 || bus.wr_addr_o !== 4'd0 || bus.wr_data_o !== 32'd0 || bus.busy_o !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: got en=%b addr=%0d data=%h busy=%h, want 0/0/0/0",
               bus.wr_enable_o, bus.wr_addr_o, bus.wr_data_o, bus.busy_o);
    end
    @(negedge clk) rst_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk) begin bus.reserve_valid_i = 1'b1; bus.reserve_addr_i = 4'd0; end
    @(negedge clk) bus.reserve_addr_i = 4'd2;
    @(negedge clk) begin
      bus.reserve_valid_i = 1'b0;
      bus.alu_valid_i = 1'b1; bus.alu_addr_i = 4'd4; bus.alu_data_i = 32'h1234_5678;
    end
    @(posedge clk) #1;
    checks++;
    if (bus.busy_o !== 16'h0005 || bus.wr_enable_o !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: got busy=%h en=%b, want 0005/1", bus.busy_o, bus.wr_enable_o);
    end
    bus.alu_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (bus.busy_o !== 16'h0 || bus.wr_enable_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got busy=%h en=%b, want 0000/0", bus.busy_o, bus.wr_enable_o);
    end
    @(negedge clk) rst_i = 1'b0;
    @(negedge clk) begin
      bus.alu_valid_i = 1'b1; bus.alu_addr_i = 4'd1; bus.alu_data_i = 32'hA;
      bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 4'd2; bus.lsu_data_i = 32'hB;
    end
    #1;
    checks++;
    if (bus.alu_ready_o !== 1'b1 || bus.lsu_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ptr: got alu_ready=%b lsu_ready=%b, want 1/0", bus.alu_ready_o, bus.lsu_ready_o);
    end
    @(negedge clk) begin bus.alu_valid_i = 1'b0; bus.lsu_valid_i = 1'b0; end
  endtask

  task automatic test_single_alu;
    @(negedge clk) begin bus.alu_valid_i = 1'b1; bus.alu_addr_i = 4'd3; bus.alu_data_i = 32'hDEAD_BEEF; end
    #1;
    checks++;
    if (bus.alu_ready_o !== 1'b1 || bus.lsu_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL alu_ready: got alu=%b lsu=%b, want 1/0", bus.alu_ready_o, bus.lsu_ready_o);
    end
    @(posedge clk) #1;
    checks++;
    if (bus.wr_enable_o !== 1'b1 || bus.wr_addr_o !== 4'd3 || bus.wr_data_o !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL alu_write: got en=%b addr=%0d data=%h, want 1/3/deadbeef",
               bus.wr_enable_o, bus.wr_addr_o, bus.wr_data_o);
    end
    @(negedge clk) bus.alu_valid_i = 1'b0;
    #1;
    checks++;
    if (bus.alu_ready_o !== 1'b0 || bus.lsu_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready: got alu=%b lsu=%b, want 0/0", bus.alu_ready_o, bus.lsu_ready_o);
    end
    @(posedge clk) #1;
    checks++;
    if (bus.wr_enable_o !== 1'b0 || bus.wr_addr_o !== 4'd3 || bus.wr_data_o !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL alu_hold: got en=%b addr=%0d data=%h, want 0/3/deadbeef",
               bus.wr_enable_o, bus.wr_addr_o, bus.wr_data_o);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_alu;
    @(negedge clk) begin bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 4'd6; bus.lsu_data_i = 32'h0000_0066; end
    #1;
    checks++;
    if (bus.lsu_ready_o !== 1'b1 || bus.alu_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL lsu_ready: got lsu=%b alu=%b, want 1/0", bus.lsu_ready_o, bus.alu_ready_o);
    end
    @(negedge clk) begin
      bus.alu_valid_i = 1'b1; bus.alu_addr_i = 4'd1; bus.alu_data_i = 32'h0000_00A1;
      bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 4'd2; bus.lsu_data_i = 32'h0000_00B2;
    end
    for (int i = 0; i < 4; i++) begin
      exp_alu = (i % 2 == 0);
      #1;
      checks++;
      if (bus.alu_ready_o !== exp_alu || bus.lsu_ready_o !== !exp_alu) begin
        failures++;
        $display("FAIL contention_grant[%0d]: got alu=%b lsu=%b, want %b/%b",
                 i, bus.alu_ready_o, bus.lsu_ready_o, exp_alu, !exp_alu);
      end
      @(posedge clk) #1;
      checks++;
      if (bus.wr_enable_o !== 1'b1 || bus.wr_addr_o !== (exp_alu ? 4'd1 : 4'd2) ||
          bus.wr_data_o !== (exp_alu ? 32'hA1 : 32'hB2)) begin
        failures++;
        $display("FAIL contention_write[%0d]: got en=%b addr=%0d data=%h", i, bus.wr_enable_o, bus.wr_addr_o, bus.wr_data_o);
      end
      @(negedge clk);
    end
    bus.alu_valid_i = 1'b0; bus.lsu_valid_i = 1'b0;
    @(posedge clk) #1;
    checks++;
    if (bus.wr_enable_o !== 1'b0) begin
      failures++;
      $display("FAIL contention_end: got en=%b, want 0", bus.wr_enable_o);
    end
  endtask

  task automatic test_scoreboard;
    @(negedge clk) begin bus.reserve_valid_i = 1'b1; bus.reserve_addr_i = 4'd5; end
    @(negedge clk) begin bus.reserve_valid_i = 1'b0; bus.rd_addr1_i = 4'd5; end
    #1;
    checks++;
    if (bus.busy_o !== 16'h0020 || bus.hazard1_o !== 1'b1) begin
      failures++;
      $display("FAIL reserve_r5: got busy=%h hz1=%b, want 0020/1", bus.busy_o, bus.hazard1_o);
    end
    @(negedge clk) begin bus.alu_valid_i = 1'b1; bus.alu_addr_i = 4'd5; bus.alu_data_i = 32'h5555_5555; end
    #1;
    checks++;
    if (bus.hazard1_o !== 1'b1) begin
      failures++;
      $display("FAIL hazard_pending: got hz1=%b, want 1", bus.hazard1_o);
    end
    @(posedge clk) #1;
    checks++;
    if (bus.wr_enable_o !== 1'b1 || bus.wr_addr_o !== 4'd5 || bus.hazard1_o !== 1'b1) begin
      failures++;
      $display("FAIL hazard_wr_cycle: got en=%b addr=%0d hz1=%b, want 1/5/1", bus.wr_enable_o, bus.wr_addr_o, bus.hazard1_o);
    end
    @(negedge clk) bus.alu_valid_i = 1'b0;
    @(posedge clk) #1;
    checks++;
    if (bus.hazard1_o !== 1'b0 || bus.busy_o !== 16'h0) begin
      failures++;
      $display("FAIL hazard_clear: got hz1=%b busy=%h, want 0/0000", bus.hazard1_o, bus.busy_o);
    end
  endtask

  task automatic test_simultaneous;
    @(negedge clk) begin bus.reserve_valid_i = 1'b1; bus.reserve_addr_i = 4'd7; end
    @(negedge clk) begin
      bus.reserve_valid_i = 1'b0;
      bus.alu_valid_i = 1'b1; bus.alu_addr_i = 4'd7; bus.alu_data_i = 32'h0000_0777;
    end
    @(negedge clk) begin bus.alu_valid_i = 1'b0; bus.reserve_valid_i = 1'b1; bus.reserve_addr_i = 4'd7; end
    #1;
    checks++;
    if (bus.wr_enable_o !== 1'b1 || bus.wr_addr_o !== 4'd7) begin
      failures++;
      $display("FAIL simul_write: got en=%b addr=%0d, want 1/7", bus.wr_enable_o, bus.wr_addr_o);
    end
    @(negedge clk) begin bus.reserve_valid_i = 1'b0; bus.rd_addr2_i = 4'd7; end
    #1;
    checks++;
    if (bus.busy_o !== 16'h0080 || bus.hazard2_o !== 1'b1) begin
      failures++;
      $display("FAIL simul_set_wins: got busy=%h hz2=%b, want 0080/1", bus.busy_o, bus.hazard2_o);
    end
  endtask

  task automatic test_idle_write;
    @(negedge clk) begin
      bus.rd_addr1_i = 4'd9; bus.rd_addr2_i = 4'd9;
      bus.alu_valid_i = 1'b1; bus.alu_addr_i = 4'd9; bus.alu_data_i = 32'h0999_0999;
    end
    #1;
    checks++;
    if (bus.hazard1_o !== 1'b0 || bus.hazard2_o !== 1'b0 || bus.alu_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL idle_hazard: got hz1=%b hz2=%b ready=%b, want 0/0/1", bus.hazard1_o, bus.hazard2_o, bus.alu_ready_o);
    end
    @(posedge clk) #1;
    checks++;
    if (bus.wr_enable_o !== 1'b1 || bus.wr_addr_o !== 4'd9 || bus.wr_data_o !== 32'h0999_0999 || bus.busy_o !== 16'h0080) begin
      failures++;
      $display("FAIL idle_write: got en=%b addr=%0d data=%h busy=%h, want 1/9/09990999/0080",
               bus.wr_enable_o, bus.wr_addr_o, bus.wr_data_o, bus.busy_o);
    end
    @(negedge clk) bus.alu_valid_i = 1'b0;
    @(posedge clk) #1;
    checks++;
    if (bus.busy_o !== 16'h0080 || bus.hazard1_o !== 1'b0 || bus.hazard2_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_after: got busy=%h hz1=%b hz2=%b, want 0080/0/0", bus.busy_o, bus.hazard1_o, bus.hazard2_o);
    end
  endtask

  initial begin
    bus.alu_valid_i = 1'b0; bus.alu_addr_i = '0; bus.alu_data_i = '0;
    bus.lsu_valid_i = 1'b0; bus.lsu_addr_i = '0; bus.lsu_data_i = '0;
    bus.reserve_valid_i = 1'b0; bus.reserve_addr_i = '0;
    bus.rd_addr1_i = '0; bus.rd_addr2_i = '0;
    test_reset();
    test_reset_mid();
    test_single_alu();
    test_back_to_back();
    test_scoreboard();
    test_simultaneous();
    test_idle_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
